mem_stage: RTL and testbench

Memory-access stage of the five-stage pipeline, sitting between the EX/MEM register and the MEM/WB register. Performs data-memory loads and stores against an internal word-addressed array with a parameterised multi-cycle access latency. Asserts a stall to freeze the front of the pipeline while an access is in flight, and inserts a bubble toward MEM/WB until the access completes. Non-memory instructions pass through in one cycle.

---
 rtl/mem_stage_pkg.sv | 19 +
 rtl/dmem_array.sv | 33 +++
 rtl/mem_stage.sv | 127 ++++++++++++
 tb/tb_mem_stage.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_stage_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mem_stage_pkg
//  Purpose  : Shared pipeline types and constants for the memory stage.
//  Revision : 1.0  initial release
// ============================================================================
package mem_stage_pkg;

    localparam int c_DATA_W     = 32;
    localparam int c_REG_ADDR_W = 5;
    localparam int MIN_LATENCY  = 1;

    // Memory-stage FSM state encoding
    typedef logic [0:0] memState_t;
    localparam memState_t c_ST_IDLE = 1'b0;
    localparam memState_t c_ST_BUSY = 1'b1;

endpackage
`default_nettype wire

// File: rtl/dmem_array.sv
`default_nettype none
// ============================================================================
//  Module   : dmem_array
//  Purpose  : DEPTH x 32 data memory, synchronous write, asynchronous read.
//             Contents are deliberately not reset.
//  Revision : 1.0  initial release
// ============================================================================
module dmem_array
    import mem_stage_pkg::*;
#(
    parameter int DEPTH = 256,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic                clk_i,
    input  logic                we_i,
    input  logic [AW-1:0]       addr_i,
    input  logic [c_DATA_W-1:0] wdata_i,
    output logic [c_DATA_W-1:0] rdata_o
);

    logic [c_DATA_W-1:0] r_mem [DEPTH];

    // Commit a store on the rising edge when enabled
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            r_mem[addr_i] <= wdata_i;
        end
    end

    assign rdata_o = r_mem[addr_i];

endmodule
`default_nettype wire

// File: rtl/mem_stage.sv
`default_nettype none
// ============================================================================
//  Module   : mem_stage
//  Purpose  : Pipeline MEM stage. Multi-cycle data-memory access with stall
//             toward the front end and bubble insertion toward MEM/WB.
//  Revision : 1.0  initial release
// ============================================================================
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int DEPTH   = 256,
    parameter int LATENCY = 2
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    MemRead_i,
    input  logic                    MemWrite_i,
    input  logic                    RegWrite_i,
    input  logic                    MemtoReg_i,
    input  logic [c_DATA_W-1:0]     ALUdata_i,
    input  logic [c_DATA_W-1:0]     WriteData_i,
    input  logic [c_REG_ADDR_W-1:0] RDaddr_i,
    output logic                    stall_o,
    output logic                    RegWrite_o,
    output logic                    MemtoReg_o,
    output logic [c_DATA_W-1:0]     ReadData_o,
    output logic [c_DATA_W-1:0]     ALUdata_o,
    output logic [c_REG_ADDR_W-1:0] RDaddr_o,
    output logic                    misalign_o
);

    localparam int c_AW = $clog2(DEPTH);
    localparam int c_CW = $clog2(LATENCY) + 1;
    // First edge out of IDLE already accounts for one cycle of the access
    localparam logic [c_CW-1:0] c_CNT_LOAD =
        (LATENCY > MIN_LATENCY) ? c_CW'(LATENCY - 2) : '0;

    memState_t         r_state;
    memState_t         w_stateNext;
    logic [c_CW-1:0]   r_cnt;
    logic [c_CW-1:0]   w_cntNext;

    logic              w_memOp;
    logic              w_misalign;
    logic              w_alignedOp;
    logic              w_cntZero;
    logic              w_complete;
    logic              w_stall;
    logic              w_we;
    logic [c_AW-1:0]   w_index;
    logic [c_DATA_W-1:0] w_rdata;

    assign w_memOp     = MemRead_i | MemWrite_i;
    assign w_misalign  = w_memOp & (ALUdata_i[1:0] != 2'b00);
    assign w_alignedOp = w_memOp & ~w_misalign;
    assign w_cntZero   = (r_cnt == '0);
    assign w_index     = ALUdata_i[c_AW+1:2];

    // Completion: last cycle of a BUSY access, or the only cycle when LATENCY is 1
    assign w_complete = w_alignedOp &
                        (((r_state == c_ST_BUSY) & w_cntZero) |
                         ((r_state == c_ST_IDLE) & (LATENCY == MIN_LATENCY)));

    // Reset forces stall low immediately, even with a memory op on the inputs
    assign w_stall = ~rst_i & w_alignedOp &
                     (((r_state == c_ST_IDLE) & (LATENCY > MIN_LATENCY)) |
                      ((r_state == c_ST_BUSY) & ~w_cntZero));

    // A store wins over a simultaneous read; nothing commits while in reset
    assign w_we = ~rst_i & w_complete & MemWrite_i;

    dmem_array #(
        .DEPTH (DEPTH)
    ) u_dmem (
        .clk_i   (clk_i),
        .we_i    (w_we),
        .addr_i  (w_index),
        .wdata_i (WriteData_i),
        .rdata_o (w_rdata)
    );

    // State and countdown register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= c_ST_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_stateNext;
            r_cnt   <= w_cntNext;
        end
    end

    // Next-state and countdown logic
    always_comb begin
        w_stateNext = r_state;
        w_cntNext   = r_cnt;
        case (r_state)
            c_ST_IDLE: begin
                if (w_alignedOp && (LATENCY > MIN_LATENCY)) begin
                    w_stateNext = c_ST_BUSY;
                    w_cntNext   = c_CNT_LOAD;
                end
            end
            c_ST_BUSY: begin
                if (!w_cntZero) begin
                    w_cntNext = r_cnt - c_CW'(1);
                end else begin
                    w_stateNext = c_ST_IDLE;
                end
            end
            default: begin
                w_stateNext = c_ST_IDLE;
                w_cntNext   = '0;
            end
        endcase
    end

    assign stall_o    = w_stall;
    assign misalign_o = ~rst_i & w_misalign;
    assign RegWrite_o = w_stall ? 1'b0 : RegWrite_i;
    assign MemtoReg_o = w_stall ? 1'b0 : MemtoReg_i;
    assign ALUdata_o  = ALUdata_i;
    assign RDaddr_o   = RDaddr_i;
    assign ReadData_o = (~rst_i & w_complete & MemRead_i & ~MemWrite_i) ? w_rdata : '0;

endmodule
`default_nettype wire

// File: tb/tb_mem_stage.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_stage
//  Purpose  : Directed self-checking bench for mem_stage; four instances with
//             LATENCY 1..4 share the same stimulus, each test inspects one.
//  Revision : 1.0  initial release
// ============================================================================
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        MemRead, MemWrite, RegWrite, MemtoReg;
    logic [31:0] ALUdata, WriteData;
    logic [4:0]  RDaddr;

    logic        stallO [4];
    logic        regWO  [4];
    logic        m2rO   [4];
    logic        misO   [4];
    logic [31:0] rdO    [4];
    logic [31:0] aluO   [4];
    logic [4:0]  rdaO   [4];

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        mem_stage #(
            .DEPTH   (256),
            .LATENCY (g + 1)
        ) u_dut (
            .clk_i       (clk),
            .rst_i       (rst),
            .MemRead_i   (MemRead),
            .MemWrite_i  (MemWrite),
            .RegWrite_i  (RegWrite),
            .MemtoReg_i  (MemtoReg),
            .ALUdata_i   (ALUdata),
            .WriteData_i (WriteData),
            .RDaddr_i    (RDaddr),
            .stall_o     (stallO[g]),
            .RegWrite_o  (regWO[g]),
            .MemtoReg_o  (m2rO[g]),
            .ReadData_o  (rdO[g]),
            .ALUdata_o   (aluO[g]),
            .RDaddr_o    (rdaO[g]),
            .misalign_o  (misO[g])
        );
    end

    task automatic setOp(input logic rd, input logic wr, input logic rw, input logic m2r,
                         input logic [31:0] addr, input logic [31:0] wd, input logic [4:0] rda);
        MemRead = rd; MemWrite = wr; RegWrite = rw; MemtoReg = m2r;
        ALUdata = addr; WriteData = wd; RDaddr = rda;
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    // Hold reset across one edge, then release with a bubble on the inputs
    task automatic doReset();
        rst = 1'b1;
        setOp(0, 0, 0, 0, 32'h0, 32'h0, 5'd0);
        nextCycle();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        setOp(1, 0, 1, 1, 32'h10, 32'h0, 5'd3);
        nextCycle();
        #1;
        for (int g = 0; g < 4; g++) begin
            checks++;
            if (stallO[g] !== 1'b0) begin
                errors++; $display("FAIL reset_stall lat%0d: got %b want 0", g + 1, stallO[g]);
            end
            checks++;
            if (rdO[g] !== 32'h0) begin
                errors++; $display("FAIL reset_rdata lat%0d: got %h want 0", g + 1, rdO[g]);
            end
        end
        ALUdata = 32'h13;
        #1;
        for (int g = 0; g < 4; g++) begin
            checks++;
            if (misO[g] !== 1'b0) begin
                errors++; $display("FAIL reset_misalign lat%0d: got %b want 0", g + 1, misO[g]);
            end
        end
        doReset();
    endtask

    task automatic test_pass_through();
        doReset();
        setOp(0, 0, 1, 0, 32'h1234, 32'h0, 5'd5);
        #2;
        checks++;
        if ({stallO[1], regWO[1], m2rO[1], misO[1]} !== 4'b0100 || aluO[1] !== 32'h1234 ||
            rdaO[1] !== 5'd5 || rdO[1] !== 32'h0) begin
            errors++;
            $display("FAIL pass_add: got st=%b rw=%b m2r=%b mis=%b alu=%h rd=%0d rdata=%h want 0 1 0 0 1234 5 0",
                     stallO[1], regWO[1], m2rO[1], misO[1], aluO[1], rdaO[1], rdO[1]);
        end
        nextCycle();
        setOp(0, 0, 0, 1, 32'hFFFF_FFF3, 32'h0, 5'd31);
        #2;
        checks++;
        if ({stallO[1], regWO[1], m2rO[1], misO[1]} !== 4'b0010 || aluO[1] !== 32'hFFFF_FFF3 ||
            rdaO[1] !== 5'd31 || rdO[1] !== 32'h0) begin
            errors++;
            $display("FAIL pass_nonmem_oddaddr: got st=%b rw=%b m2r=%b mis=%b alu=%h rd=%0d rdata=%h want 0 0 1 0 fffffff3 31 0",
                     stallO[1], regWO[1], m2rO[1], misO[1], aluO[1], rdaO[1], rdO[1]);
        end
        nextCycle();
    endtask

    task automatic test_store_load();
        doReset();
        setOp(0, 1, 0, 0, 32'h40, 32'hDEAD_BEEF, 5'd0);
        for (int c = 0; c < 3; c++) begin
            #2;
            checks++;
            if (stallO[2] !== logic'(c < 2) || regWO[2] !== 1'b0) begin
                errors++;
                $display("FAIL store_cycle%0d: got stall=%b rw=%b want stall=%b rw=0",
                         c, stallO[2], regWO[2], logic'(c < 2));
            end
            nextCycle();
        end
        setOp(1, 0, 1, 1, 32'h40, 32'h0, 5'd7);
        for (int c = 0; c < 3; c++) begin
            #2;
            checks++;
            if (stallO[2] !== logic'(c < 2) || regWO[2] !== logic'(c == 2) ||
                m2rO[2] !== logic'(c == 2) || rdaO[2] !== 5'd7 ||
                rdO[2] !== ((c == 2) ? 32'hDEAD_BEEF : 32'h0)) begin
                errors++;
                $display("FAIL load_cycle%0d: got stall=%b rw=%b m2r=%b rd=%0d rdata=%h want stall=%b rw=%b m2r=%b rd=7 rdata=%h",
                         c, stallO[2], regWO[2], m2rO[2], rdaO[2], rdO[2], logic'(c < 2),
                         logic'(c == 2), logic'(c == 2), (c == 2) ? 32'hDEAD_BEEF : 32'h0);
            end
            nextCycle();
        end
    endtask

    task automatic test_misaligned();
        setOp(0, 1, 0, 0, 32'h42, 32'h1, 5'd0);
        #2;
        checks++;
        if (misO[2] !== 1'b1 || stallO[2] !== 1'b0) begin
            errors++; $display("FAIL mis_store: got mis=%b stall=%b want 1 0", misO[2], stallO[2]);
        end
        nextCycle();
        setOp(1, 0, 1, 1, 32'h41, 32'h0, 5'd9);
        #2;
        checks++;
        if (misO[2] !== 1'b1 || stallO[2] !== 1'b0 || rdO[2] !== 32'h0 || regWO[2] !== 1'b1) begin
            errors++;
            $display("FAIL mis_load: got mis=%b stall=%b rdata=%h rw=%b want 1 0 0 1",
                     misO[2], stallO[2], rdO[2], regWO[2]);
        end
        nextCycle();
        setOp(1, 0, 1, 1, 32'h40, 32'h0, 5'd7);
        nextCycle();
        nextCycle();
        #1;
        checks++;
        if (rdO[2] !== 32'hDEAD_BEEF) begin
            errors++; $display("FAIL mis_prior_contents: got %h want deadbeef", rdO[2]);
        end
        nextCycle();
    endtask

    task automatic test_wrap();
        setOp(0, 1, 0, 0, 32'h400, 32'h55, 5'd0);
        nextCycle(); nextCycle(); nextCycle();
        setOp(1, 0, 1, 1, 32'h000, 32'h0, 5'd2);
        nextCycle(); nextCycle();
        #1;
        checks++;
        if (rdO[2] !== 32'h55 || stallO[2] !== 1'b0) begin
            errors++; $display("FAIL wrap_load: got rdata=%h stall=%b want 55 0", rdO[2], stallO[2]);
        end
        nextCycle();
    endtask

    task automatic test_reset_mid();
        doReset();
        setOp(0, 1, 0, 0, 32'h10, 32'h1111, 5'd0);
        nextCycle(); nextCycle(); nextCycle(); nextCycle();
        setOp(0, 1, 0, 0, 32'h10, 32'hAAAA, 5'd0);
        nextCycle();
        #1;
        checks++;
        if (stallO[3] !== 1'b1) begin
            errors++; $display("FAIL rstmid_pre: got stall=%b want 1", stallO[3]);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (stallO[3] !== 1'b0 || misO[3] !== 1'b0 || rdO[3] !== 32'h0) begin
            errors++;
            $display("FAIL rstmid_async: got stall=%b mis=%b rdata=%h want 0 0 0", stallO[3], misO[3], rdO[3]);
        end
        nextCycle();
        rst = 1'b0;
        setOp(0, 0, 0, 0, 32'h0, 32'h0, 5'd0);
        #2;
        checks++;
        if (stallO[3] !== 1'b0) begin
            errors++; $display("FAIL rstmid_idle: got stall=%b want 0", stallO[3]);
        end
        nextCycle();
        setOp(1, 0, 1, 1, 32'h10, 32'h0, 5'd4);
        for (int c = 0; c < 4; c++) begin
            #2;
            checks++;
            if (stallO[3] !== logic'(c < 3) || rdO[3] !== ((c == 3) ? 32'h1111 : 32'h0)) begin
                errors++;
                $display("FAIL rstmid_load_cycle%0d: got stall=%b rdata=%h want %b %h",
                         c, stallO[3], rdO[3], logic'(c < 3), (c == 3) ? 32'h1111 : 32'h0);
            end
            nextCycle();
        end
    endtask

    task automatic test_back_to_back();
        doReset();
        setOp(1, 1, 0, 0, 32'h8, 32'h7, 5'd0);
        #2;
        checks++;
        if (stallO[0] !== 1'b0 || rdO[0] !== 32'h0) begin
            errors++; $display("FAIL lat1_conflict: got stall=%b rdata=%h want 0 0", stallO[0], rdO[0]);
        end
        nextCycle();
        setOp(1, 0, 1, 1, 32'h8, 32'h0, 5'd6);
        #2;
        checks++;
        if (stallO[0] !== 1'b0 || rdO[0] !== 32'h7 || regWO[0] !== 1'b1) begin
            errors++;
            $display("FAIL lat1_load_after_store: got stall=%b rdata=%h rw=%b want 0 7 1",
                     stallO[0], rdO[0], regWO[0]);
        end
        nextCycle();
    endtask

    initial begin
        setOp(0, 0, 0, 0, 32'h0, 32'h0, 5'd0);
        test_reset();
        test_pass_through();
        test_store_load();
        test_misaligned();
        test_wrap();
        test_reset_mid();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
